lane_hazard_tracker: RTL and testbench
======================================

Name: lane_hazard_tracker

Overview:
- Parametrised successor to the per-object lane registers and collision/game-state logic.
- Holds the player lane and N hazard-channel lane masks across a configurable lane count.
- Detects overlaps once per check window and owns the lives counter, including invulnerability/explosion hold timing and game-over.
- Sits between the control FSM (load/check strobes) and the VGA draw/score path.

Parameters:
- LANES, 3, number of road lanes; one bit per lane in every position mask.
- HAZARDS, 2, number of hazard channels (for example, 0 = car, 1 = banana).
- DAMAGE_MASK, 2'b01, bit i = 1 means a channel-i hit costs a life; 0 means a hit pulse only.
- LIVES, 2, starting lives; must be >= 1.
- HOLD_CYCLES, 50000000, explosion/invulnerability window in clk cycles; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous game restart; same effect as reset.
- player_load  in  1  latch player_lane_in.
- player_lane_in  in  LANES  requested player lane, one-hot.
- hazard_load  in  HAZARDS  per-channel latch strobe.
- hazard_in  in  HAZARDS*LANES  channel i occupies bits [i*LANES +: LANES].
- check  in  HAZARDS  per-channel collision-check window.
- player_pos  out  LANES  registered player lane.
- hazard_pos  out  HAZARDS*LANES  registered hazard masks.
- hit  out  HAZARDS  one-cycle pulse per channel hit.
- lane_err  out  1  one-cycle pulse when player_lane_in is not one-hot.
- lives  out  $clog2(LIVES+1)  remaining lives.
- explosion  out  1  high during the hold window.
- game_over  out  1  high in the DEAD state.

Behaviour:
- Reset or clear, with reset having priority, sets:
  - player_pos to one-hot bit LANES/2;
  - hazard_pos to 0 and hit to 0;
  - lives to LIVES;
  - explosion, game_over and lane_err to 0;
  - every arm[i] to 1;
  - hold counter to 0 and state to ALIVE.
- Reset/clear overrides every load and check issued in the same cycle.
- player_load:
  - If player_lane_in has exactly one bit set, player_pos takes it next cycle.
  - Otherwise player_pos is held and lane_err pulses for 1 cycle.
- hazard_load[i]: the channel-i slice takes hazard_in next cycle. Any mask is legal, including 0 and all-ones.
- Overlap: ovl[i] = |(player_pos & hazard_pos slice i), computed from current registered values. A same-cycle load affects only the next cycle's check.
- Arming: arm[i] is set to 1 in any cycle where check[i] = 0.
- Hit: when check[i] & arm[i] & ovl[i], hit[i] = 1 next cycle and arm[i] is cleared. This gives at most one hit per continuous check window per channel. Latency is 1 cycle.
- Damaging hit event: any hit with DAMAGE_MASK[i] = 1 in a cycle. Multiple damaging channels in the same cycle count as ONE event.
- State machine:
  - ALIVE:
    - On a damaging event with lives > 1: lives decrements, explosion goes to 1, counter loads HOLD_CYCLES-1, go to INVUL.
    - On a damaging event with lives == 1: lives goes to 0, explosion goes to 1, game_over goes to 1, go to DEAD.
  - INVUL:
    - Counter decrements each cycle.
    - Damaging hits still pulse hit but do not change lives.
    - When the counter == 0: explosion goes to 0, go to ALIVE.
    - The window is exactly HOLD_CYCLES cycles of explosion = 1.
  - DEAD:
    - player_load, hazard_load and check are ignored.
    - hit stays 0 and explosion stays 1.
    - The block holds until reset/clear.
- lives never underflows. game_over = (state == DEAD).
- Non-damaging hits pulse hit in every state except DEAD.

Decomposition:
- Shared package holds:
  - the state enum (ALIVE, INVUL, DEAD);
  - a helper function for the one-hot check;
  - a helper function for the lane-overlap reduction.
- Sub-module hazard_channel (generate-instantiated HAZARDS times) holds one slice register, its arm flag, the overlap term and the hit pulse.
- The top level holds player_pos, the lives/state FSM and the hold counter.

Test Plan (all tests use LANES=3, HAZARDS=2, DAMAGE_MASK=01, LIVES=2 and a small HOLD_CYCLES override of 4):
1. Reset, then player_load 3'b100, then 3'b011 -> player_pos = 010 after reset; 100 one cycle after the first load; second load holds 100 with lane_err = 1 for exactly one cycle.
2. Hazard 0 loaded to 110, player at 010, check[0] held high for 5 cycles -> hit[0] pulses once; lives 2→1; explosion high for exactly 4 cycles; then state ALIVE.
3. During INVUL, a second check[0] window with overlap -> hit[0] pulses, lives stays 1.
4. Hazard 0 and hazard 1 both overlap the player and are checked in the same cycle while ALIVE with lives = 2 -> hit = 2'b11, lives decrements by one only.
5. Two damaging windows separated by more than 4 cycles -> lives reaches 0, game_over = 1; subsequent player_load and check are ignored; clear restores lives = 2 and player_pos = 010.
6. hazard_load with a new mask and check asserted in the same cycle -> hit reflects the old mask; reset asserted mid-INVUL -> all outputs return to their reset values next cycle.

Source files
------------

// File: rtl/lane_hazard_tracker_pkg.sv
// Shared types and helpers for the lane/hazard collision tracker.
// Lane masks are passed to the helpers zero-extended to MASK_W bits, so LANES must not exceed MASK_W.
package lane_hazard_tracker_pkg;

    localparam int MASK_W = 32;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_INVUL = 2'd1,
        ST_DEAD  = 2'd2
    } state_e;

    function automatic logic is_onehot(input logic [MASK_W-1:0] v);
        return (v != '0) && ((v & (v - MASK_W'(1))) == '0);
    endfunction

    function automatic logic lanes_overlap(input logic [MASK_W-1:0] a,
                                           input logic [MASK_W-1:0] b);
        return |(a & b);
    endfunction

endpackage

// File: rtl/lane_hazard_tracker_if.sv
// Bus between the control FSM / draw path and the lane hazard tracker.
// All inputs are single-cycle strobes sampled on the rising clk edge; there is no back-pressure.
interface lane_hazard_tracker_if #(
    parameter int LANES   = 3,
    parameter int HAZARDS = 2,
    parameter int LIVES   = 2
);
    import lane_hazard_tracker_pkg::*;

    localparam int LW = $clog2(LIVES + 1);

    logic                       clear;
    logic                       player_load;
    logic [LANES-1:0]           player_lane_in;
    logic [HAZARDS-1:0]         hazard_load;
    logic [HAZARDS*LANES-1:0]   hazard_in;
    logic [HAZARDS-1:0]         check;
    logic [LANES-1:0]           player_pos;
    logic [HAZARDS*LANES-1:0]   hazard_pos;
    logic [HAZARDS-1:0]         hit;
    logic                       lane_err;
    logic [LW-1:0]              lives;
    logic                       explosion;
    logic                       game_over;
    state_e                     state;

    modport master (
        output clear, player_load, player_lane_in, hazard_load, hazard_in, check,
        input  player_pos, hazard_pos, hit, lane_err, lives, explosion, game_over, state
    );

    modport slave (
        input  clear, player_load, player_lane_in, hazard_load, hazard_in, check,
        output player_pos, hazard_pos, hit, lane_err, lives, explosion, game_over, state
    );

endinterface

// File: rtl/lane_hazard_tracker_hazard_channel.sv
// One hazard channel: lane mask register, re-arm flag and one-shot hit pulse per check window.
module hazard_channel
    import lane_hazard_tracker_pkg::*;
#(
    parameter int LANES = 3
) (
    input  logic             clk,
    input  logic             restart_i,
    input  logic             enable_i,
    input  logic             load_i,
    input  logic [LANES-1:0] lane_i,
    input  logic             check_i,
    input  logic [LANES-1:0] player_pos_i,
    output logic [LANES-1:0] pos_o,
    output logic             hit_next_o,
    output logic             hit_o
);

    logic [LANES-1:0] pos_q;
    logic             arm_q;
    logic             hit_q;
    logic             check_en;
    logic             ovl;

    assign check_en   = check_i & enable_i;
    // Overlap uses registered values only, so a same-cycle load is seen by the next check.
    assign ovl        = lanes_overlap(MASK_W'(player_pos_i), MASK_W'(pos_q));
    assign hit_next_o = check_en & arm_q & ovl;

    always_ff @(posedge clk) begin
        if (restart_i) begin
            pos_q <= '0;
            arm_q <= 1'b1;
            hit_q <= 1'b0;
        end else begin
            if (load_i && enable_i) begin
                pos_q <= lane_i;
            end
            if (!check_en) begin
                arm_q <= 1'b1;
            end else if (hit_next_o) begin
                arm_q <= 1'b0;
            end
            hit_q <= hit_next_o;
        end
    end

    assign pos_o = pos_q;
    assign hit_o = hit_q;

endmodule

// File: rtl/lane_hazard_tracker.sv
// Player lane register, hazard channels, and the lives / invulnerability / game-over FSM.
module lane_hazard_tracker
    import lane_hazard_tracker_pkg::*;
#(
    parameter int                 LANES       = 3,
    parameter int                 HAZARDS     = 2,
    parameter logic [HAZARDS-1:0] DAMAGE_MASK = HAZARDS'(2'b01),
    parameter int                 LIVES       = 2,
    parameter int                 HOLD_CYCLES = 50000000
) (
    input  logic                  clk,
    input  logic                  reset,
    lane_hazard_tracker_if.slave  bus
);

    localparam int LW = $clog2(LIVES + 1);
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [LANES-1:0] PLAYER_RESET = LANES'(1) << (LANES / 2);

    logic               restart;
    logic               alive_en;
    logic               dmg;
    logic [HAZARDS-1:0] hit_next;
    logic [HAZARDS-1:0] hit_w;

    logic [LANES-1:0]   player_q, player_d;
    logic               err_q, err_d;
    logic [LW-1:0]      lives_q, lives_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    state_e             state_q, state_d;

    assign restart  = reset | bus.clear;
    assign alive_en = (state_q != ST_DEAD);

    for (genvar g = 0; g < HAZARDS; g++) begin : g_chan
        hazard_channel #(.LANES(LANES)) u_chan (
            .clk          (clk),
            .restart_i    (restart),
            .enable_i     (alive_en),
            .load_i       (bus.hazard_load[g]),
            .lane_i       (bus.hazard_in[g*LANES +: LANES]),
            .check_i      (bus.check[g]),
            .player_pos_i (player_q),
            .pos_o        (bus.hazard_pos[g*LANES +: LANES]),
            .hit_next_o   (hit_next[g]),
            .hit_o        (hit_w[g])
        );
    end

    // Simultaneous damaging hits collapse into a single life-loss event.
    assign dmg = |(hit_next & DAMAGE_MASK);

    always_comb begin
        player_d = player_q;
        err_d    = 1'b0;
        if (bus.player_load && alive_en) begin
            if (is_onehot(MASK_W'(bus.player_lane_in))) begin
                player_d = bus.player_lane_in;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_ALIVE: begin
                if (dmg) begin
                    if (lives_q > LW'(1)) begin
                        lives_d = lives_q - LW'(1);
                        cnt_d   = CW'(HOLD_CYCLES - 1);
                        state_d = ST_INVUL;
                    end else begin
                        lives_d = '0;
                        state_d = ST_DEAD;
                    end
                end
            end
            ST_INVUL: begin
                if (cnt_q == '0) begin
                    state_d = ST_ALIVE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_DEAD: begin
                state_d = ST_DEAD;
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            player_q <= PLAYER_RESET;
            err_q    <= 1'b0;
            lives_q  <= LW'(LIVES);
            cnt_q    <= '0;
            state_q  <= ST_ALIVE;
        end else begin
            player_q <= player_d;
            err_q    <= err_d;
            lives_q  <= lives_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign bus.player_pos = player_q;
    assign bus.hit        = hit_w;
    assign bus.lane_err   = err_q;
    assign bus.lives      = lives_q;
    assign bus.explosion  = (state_q != ST_ALIVE);
    assign bus.game_over  = (state_q == ST_DEAD);
    assign bus.state      = state_q;

endmodule

// File: tb/tb_lane_hazard_tracker.sv
// Randomised and directed bench for lane_hazard_tracker against a behavioural game model.
module tb_lane_hazard_tracker;
    import lane_hazard_tracker_pkg::*;

    localparam int LANES   = 3;
    localparam int HAZARDS = 2;
    localparam int LIVES   = 2;
    localparam int HOLD    = 4;
    localparam logic [1:0] DMG = 2'b01;

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    lane_hazard_tracker_if #(.LANES(LANES), .HAZARDS(HAZARDS), .LIVES(LIVES)) bus ();

    lane_hazard_tracker #(
        .LANES(LANES), .HAZARDS(HAZARDS), .DAMAGE_MASK(DMG),
        .LIVES(LIVES), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // behavioural model of the game
    logic [2:0] m_player;
    logic [2:0] m_haz [HAZARDS];
    bit         m_arm [HAZARDS];
    logic [1:0] m_hit;
    bit         m_err;
    int         m_lives;
    int         m_hold_left;
    bit         m_invul;
    bit         m_dead;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [1:0] nh;
        if (reset || bus.clear) begin
            m_player = 3'b010;
            for (int i = 0; i < HAZARDS; i++) begin
                m_haz[i] = '0;
                m_arm[i] = 1'b1;
            end
            m_hit = '0; m_err = 0; m_lives = LIVES;
            m_hold_left = 0; m_invul = 0; m_dead = 0;
        end else if (m_dead) begin
            m_hit = '0;
            m_err = 0;
        end else begin
            nh = '0;
            for (int i = 0; i < HAZARDS; i++)
                if (bus.check[i] && m_arm[i] && ((m_player & m_haz[i]) != 0)) nh[i] = 1'b1;
            for (int i = 0; i < HAZARDS; i++)
                m_arm[i] = bus.check[i] ? (m_arm[i] && !nh[i]) : 1'b1;
            m_err = 0;
            if (bus.player_load) begin
                if ($countones(bus.player_lane_in) == 1) m_player = bus.player_lane_in;
                else m_err = 1;
            end
            for (int i = 0; i < HAZARDS; i++)
                if (bus.hazard_load[i]) m_haz[i] = bus.hazard_in[i*LANES +: LANES];
            m_hit = nh;
            if (m_invul) begin
                m_hold_left--;
                if (m_hold_left == 0) m_invul = 0;
            end else if ((nh & DMG) != 0) begin
                if (m_lives > 1) begin
                    m_lives--;
                    m_invul = 1;
                    m_hold_left = HOLD;
                end else begin
                    m_lives = 0;
                    m_dead = 1;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check_val("player_pos", 32'(bus.player_pos), 32'(m_player));
        check_val("hazard_pos", 32'(bus.hazard_pos), 32'({m_haz[1], m_haz[0]}));
        check_val("hit", 32'(bus.hit), 32'(m_hit));
        check_val("lane_err", 32'(bus.lane_err), 32'(m_err));
        check_val("lives", 32'(bus.lives), 32'(m_lives));
        check_val("explosion", 32'(bus.explosion), 32'(m_invul || m_dead));
        check_val("game_over", 32'(bus.game_over), 32'(m_dead));
    endtask

    // driver tasks
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle();
        bus.clear = 0; bus.player_load = 0; bus.player_lane_in = '0;
        bus.hazard_load = '0; bus.hazard_in = '0; bus.check = '0;
    endtask

    task automatic do_clear();
        idle();
        bus.clear = 1;
        cycle();
        bus.clear = 0;
    endtask

    int hits;
    int expl;

    initial begin
        reset = 1'b1;
        idle();
        cycle();
        cycle();
        reset = 1'b0;
        check_val("t1_reset_player", 32'(bus.player_pos), 32'(3'b010));
        check_val("t1_reset_lives", 32'(bus.lives), 32'(2));

        // T1: legal load then illegal load
        bus.player_load = 1; bus.player_lane_in = 3'b100;
        cycle();
        check_val("t1_load_100", 32'(bus.player_pos), 32'(3'b100));
        bus.player_lane_in = 3'b011;
        cycle();
        check_val("t1_err_pulse", 32'(bus.lane_err), 32'(1));
        idle();
        cycle();
        check_val("t1_err_once", 32'(bus.lane_err), 32'(0));
        check_val("t1_hold_100", 32'(bus.player_pos), 32'(3'b100));

        // T2: one long window gives one hit and a HOLD-cycle explosion
        bus.player_load = 1; bus.player_lane_in = 3'b010;
        bus.hazard_load = 2'b01; bus.hazard_in = 6'b000_110;
        cycle();
        idle();
        hits = 0; expl = 0;
        for (int k = 0; k < 12; k++) begin
            bus.check = (k < 5) ? 2'b01 : 2'b00;
            cycle();
            hits += int'(bus.hit[0]);
            expl += int'(bus.explosion);
        end
        idle();
        check_val("t2_hit_count", 32'(hits), 32'(1));
        check_val("t2_expl_len", 32'(expl), 32'(HOLD));
        check_val("t2_lives", 32'(bus.lives), 32'(1));
        check_val("t2_state", 32'(bus.state), 32'(ST_ALIVE));

        // T3: second window during INVUL still pulses hit, lives unchanged
        do_clear();
        bus.hazard_load = 2'b01; bus.hazard_in = 6'b000_110;
        cycle();
        idle();
        hits = 0;
        for (int k = 0; k < 4; k++) begin
            bus.check = (k % 2 == 0) ? 2'b01 : 2'b00;
            cycle();
            hits += int'(bus.hit[0]);
        end
        idle();
        check_val("t3_hit_count", 32'(hits), 32'(2));
        check_val("t3_lives", 32'(bus.lives), 32'(1));

        // T4: both channels hit together -> one life lost
        do_clear();
        bus.hazard_load = 2'b11; bus.hazard_in = 6'b010_010;
        cycle();
        idle();
        bus.check = 2'b11;
        cycle();
        bus.check = 2'b00;
        check_val("t4_hit_both", 32'(bus.hit), 32'(2'b11));
        check_val("t4_lives", 32'(bus.lives), 32'(1));

        // T5: wait out INVUL, second damaging window kills; DEAD ignores inputs
        for (int k = 0; k < 6; k++) cycle();
        bus.check = 2'b01;
        cycle();
        bus.check = 2'b00;
        cycle();
        check_val("t5_game_over", 32'(bus.game_over), 32'(1));
        check_val("t5_lives", 32'(bus.lives), 32'(0));
        for (int k = 0; k < 10; k++) begin
            bus.player_load = 1; bus.player_lane_in = 3'(1 << $urandom_range(0, 2));
            bus.hazard_load = 2'($urandom_range(0, 3)); bus.hazard_in = 6'($urandom_range(0, 63));
            bus.check = 2'($urandom_range(0, 3));
            cycle();
            check_val("t5_dead_hit", 32'(bus.hit), 32'(0));
        end
        check_val("t5_dead_player", 32'(bus.player_pos), 32'(3'b010));
        do_clear();
        check_val("t5_clear_lives", 32'(bus.lives), 32'(2));
        check_val("t5_clear_player", 32'(bus.player_pos), 32'(3'b010));
        check_val("t5_clear_go", 32'(bus.game_over), 32'(0));

        // T6: same-cycle load sees old mask; reset mid-INVUL
        bus.hazard_load = 2'b01; bus.hazard_in = 6'b000_010;
        cycle();
        bus.hazard_in = 6'b000_000; bus.check = 2'b01;
        cycle();
        idle();
        check_val("t6_hit_old_mask", 32'(bus.hit), 32'(2'b01));
        check_val("t6_new_mask", 32'(bus.hazard_pos), 32'(0));
        cycle();
        check_val("t6_invul", 32'(bus.state), 32'(ST_INVUL));
        reset = 1'b1;
        bus.check = 2'b11; bus.player_load = 1; bus.player_lane_in = 3'b001;
        cycle();
        reset = 1'b0;
        idle();
        check_val("t6_reset_expl", 32'(bus.explosion), 32'(0));
        check_val("t6_reset_lives", 32'(bus.lives), 32'(2));
        check_val("t6_reset_player", 32'(bus.player_pos), 32'(3'b010));
        check_val("t6_reset_state", 32'(bus.state), 32'(ST_ALIVE));

        // random soak against the model
        for (int k = 0; k < 2000; k++) begin
            bus.player_load    = ($urandom_range(0, 3) == 0);
            bus.player_lane_in = 3'($urandom_range(0, 7));
            bus.hazard_load    = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            bus.hazard_in      = 6'($urandom_range(0, 63));
            for (int i = 0; i < HAZARDS; i++)
                if ($urandom_range(0, 3) == 0) bus.check[i] = ~bus.check[i];
            bus.clear = ($urandom_range(0, 149) == 0);
            reset     = ($urandom_range(0, 299) == 0);
            cycle();
        end
        reset = 1'b0;
        idle();
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
